// File: rtl/wb_fwd_history_if.sv
// Writeback-history bus: WB capture inputs, stall/flush controls and the two
// forwarding lookup ports with their results.
interface wb_fwd_history_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
);
   logic              stall_i;
   logic              flush_i;
   logic              wb_regwrite_i;
   logic [ADDR_W-1:0] wb_wesel_i;
   logic [DATA_W-1:0] wb_data_i;
   logic [ADDR_W-1:0] rs_addr_i;
   logic [ADDR_W-1:0] rt_addr_i;
   logic              rs_hit_o;
   logic [DATA_W-1:0] rs_data_o;
   logic              rt_hit_o;
   logic [DATA_W-1:0] rt_data_o;
   logic              newest_regwrite_o;
   logic [ADDR_W-1:0] newest_wesel_o;
   logic [DATA_W-1:0] newest_data_o;
   logic [3:0]        occupancy_o;

   modport master (
      output stall_i, flush_i, wb_regwrite_i, wb_wesel_i, wb_data_i,
             rs_addr_i, rt_addr_i,
      input  rs_hit_o, rs_data_o, rt_hit_o, rt_data_o,
             newest_regwrite_o, newest_wesel_o, newest_data_o, occupancy_o
   );

   modport slave (
      input  stall_i, flush_i, wb_regwrite_i, wb_wesel_i, wb_data_i,
             rs_addr_i, rt_addr_i,
      output rs_hit_o, rs_data_o, rt_hit_o, rt_data_o,
             newest_regwrite_o, newest_wesel_o, newest_data_o, occupancy_o
   );
endinterface

// File: rtl/wb_fwd_history.sv
// Shift history of the last DEPTH WB-stage register writes with two
// combinational newest-wins forwarding lookups (rs, rt).
module wb_fwd_history #(
   parameter int DATA_W    = 32,
   parameter int ADDR_W    = 5,
   parameter int DEPTH     = 3,
   parameter int BYPASS_IN = 0
) (
   input logic              clk,
   input logic              rst,
   wb_fwd_history_if.slave  bus
);
   logic              valid_q [DEPTH];
   logic [ADDR_W-1:0] addr_q  [DEPTH];
   logic [DATA_W-1:0] data_q  [DEPTH];

   logic              live_v;
   logic [3:0]        occ;

   // Register 0 is never a real destination, so it is dropped at capture.
   assign live_v = bus.wb_regwrite_i && (bus.wb_wesel_i != '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            valid_q[i] <= 1'b0;
            addr_q[i]  <= '0;
            data_q[i]  <= '0;
         end
      end else if (bus.flush_i) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            valid_q[i] <= 1'b0;
            addr_q[i]  <= '0;
            data_q[i]  <= '0;
         end
      end else if (!bus.stall_i) begin
         for (int unsigned i = 1; i < DEPTH; i++) begin
            valid_q[i] <= valid_q[i-1];
            addr_q[i]  <= addr_q[i-1];
            data_q[i]  <= data_q[i-1];
         end
         valid_q[0] <= live_v;
         addr_q[0]  <= bus.wb_wesel_i;
         data_q[0]  <= bus.wb_data_i;
      end
   end

   // Scan oldest to newest so later (newer) matches overwrite older ones;
   // the live WB input is applied last to take top priority.
   always_comb begin
      int unsigned idx;
      bus.rs_hit_o  = 1'b0;
      bus.rs_data_o = '0;
      bus.rt_hit_o  = 1'b0;
      bus.rt_data_o = '0;
      idx = 0;
      for (int unsigned k = 0; k < DEPTH; k++) begin
         idx = DEPTH - 1 - k;
         if (valid_q[idx] && (addr_q[idx] == bus.rs_addr_i)) begin
            bus.rs_hit_o  = 1'b1;
            bus.rs_data_o = data_q[idx];
         end
         if (valid_q[idx] && (addr_q[idx] == bus.rt_addr_i)) begin
            bus.rt_hit_o  = 1'b1;
            bus.rt_data_o = data_q[idx];
         end
      end
      if ((BYPASS_IN != 0) && live_v) begin
         if (bus.wb_wesel_i == bus.rs_addr_i) begin
            bus.rs_hit_o  = 1'b1;
            bus.rs_data_o = bus.wb_data_i;
         end
         if (bus.wb_wesel_i == bus.rt_addr_i) begin
            bus.rt_hit_o  = 1'b1;
            bus.rt_data_o = bus.wb_data_i;
         end
      end
      if (bus.rs_addr_i == '0) begin
         bus.rs_hit_o  = 1'b0;
         bus.rs_data_o = '0;
      end
      if (bus.rt_addr_i == '0) begin
         bus.rt_hit_o  = 1'b0;
         bus.rt_data_o = '0;
      end
   end

   always_comb begin
      occ = '0;
      for (int unsigned k = 0; k < DEPTH; k++) begin
         if (valid_q[k]) occ = occ + 4'd1;
      end
   end

   assign bus.occupancy_o       = occ;
   assign bus.newest_regwrite_o = valid_q[0];
   assign bus.newest_wesel_o    = addr_q[0];
   assign bus.newest_data_o     = data_q[0];
endmodule

// File: tb/tb_wb_fwd_history.sv
// Bench for wb_fwd_history: two DEPTH=3 instances (BYPASS_IN 0 and 1) driven
// identically and compared against a queue-based history model.
module tb_wb_fwd_history;
   localparam int DW = 32;
   localparam int AW = 5;
   localparam int DEPTH = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;

   wb_fwd_history_if #(.DATA_W(DW), .ADDR_W(AW)) b0 ();
   wb_fwd_history_if #(.DATA_W(DW), .ADDR_W(AW)) b1 ();

   wb_fwd_history #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .BYPASS_IN(0)) dut0 (
      .clk(clk), .rst(rst), .bus(b0));
   wb_fwd_history #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .BYPASS_IN(1)) dut1 (
      .clk(clk), .rst(rst), .bus(b1));

   always #5 clk = ~clk;

   typedef struct {
      bit          v;
      bit [AW-1:0] a;
      bit [DW-1:0] d;
   } ent_t;

   ent_t hist[$];

   logic          rw, st, fl;
   logic [AW-1:0] ws, rsa, rta;
   logic [DW-1:0] wd;

   int errors = 0;
   int checks = 0;

   task automatic apply(input logic rw_n, input logic [AW-1:0] ws_n, input logic [DW-1:0] wd_n,
                        input logic st_n, input logic fl_n,
                        input logic [AW-1:0] rs_n, input logic [AW-1:0] rt_n);
      rw = rw_n; ws = ws_n; wd = wd_n; st = st_n; fl = fl_n; rsa = rs_n; rta = rt_n;
      b0.wb_regwrite_i = rw; b0.wb_wesel_i = ws; b0.wb_data_i = wd;
      b0.stall_i = st; b0.flush_i = fl; b0.rs_addr_i = rsa; b0.rt_addr_i = rta;
      b1.wb_regwrite_i = rw; b1.wb_wesel_i = ws; b1.wb_data_i = wd;
      b1.stall_i = st; b1.flush_i = fl; b1.rs_addr_i = rsa; b1.rt_addr_i = rta;
      #1;
   endtask

   task automatic model_step();
      ent_t e;
      if (rst || fl) begin
         hist.delete();
      end else if (!st) begin
         e.v = rw && (ws != 0);
         e.a = ws;
         e.d = wd;
         hist.push_front(e);
         if (hist.size() > DEPTH) void'(hist.pop_back());
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic model_lookup(input logic [AW-1:0] a, input bit byp,
                               output logic hit, output logic [DW-1:0] d);
      hit = 1'b0;
      d = '0;
      if (a != 0) begin
         if (byp && rw && ws != 0 && ws == a) begin
            hit = 1'b1;
            d = wd;
         end else begin
            foreach (hist[i]) begin
               if (!hit && hist[i].v && hist[i].a == a) begin
                  hit = 1'b1;
                  d = hist[i].d;
               end
            end
         end
      end
   endtask

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      logic          h;
      logic [DW-1:0] d;
      int            occ;
      logic          nv;
      logic [AW-1:0] na;
      logic [DW-1:0] nd;
      occ = 0;
      foreach (hist[i]) if (hist[i].v) occ++;
      nv = 1'b0; na = '0; nd = '0;
      if (hist.size() > 0) begin
         nv = hist[0].v; na = hist[0].a; nd = hist[0].d;
      end
      model_lookup(rsa, 1'b0, h, d);
      chk({tag, " b0 rs_hit"}, 32'(b0.rs_hit_o), 32'(h));
      chk({tag, " b0 rs_data"}, b0.rs_data_o, d);
      model_lookup(rta, 1'b0, h, d);
      chk({tag, " b0 rt_hit"}, 32'(b0.rt_hit_o), 32'(h));
      chk({tag, " b0 rt_data"}, b0.rt_data_o, d);
      model_lookup(rsa, 1'b1, h, d);
      chk({tag, " b1 rs_hit"}, 32'(b1.rs_hit_o), 32'(h));
      chk({tag, " b1 rs_data"}, b1.rs_data_o, d);
      model_lookup(rta, 1'b1, h, d);
      chk({tag, " b1 rt_hit"}, 32'(b1.rt_hit_o), 32'(h));
      chk({tag, " b1 rt_data"}, b1.rt_data_o, d);
      chk({tag, " b0 occupancy"}, 32'(b0.occupancy_o), 32'(occ));
      chk({tag, " b1 occupancy"}, 32'(b1.occupancy_o), 32'(occ));
      chk({tag, " b0 newest_regwrite"}, 32'(b0.newest_regwrite_o), 32'(nv));
      chk({tag, " b0 newest_wesel"}, 32'(b0.newest_wesel_o), 32'(na));
      chk({tag, " b0 newest_data"}, b0.newest_data_o, nd);
      chk({tag, " b1 newest_data"}, b1.newest_data_o, nd);
   endtask

   initial begin
      // reset state
      apply(0, 0, 0, 0, 0, 0, 0);
      repeat (2) @(posedge clk);
      #1;
      hist.delete();
      check_all("reset");
      chk("reset occupancy const", 32'(b0.occupancy_o), 32'd0);
      #2 rst = 1'b0;

      // single write then age-out through bubbles
      apply(1, 5, 32'hDEADBEEF, 0, 0, 5, 5);
      check_all("single live");
      tick();
      apply(0, 0, 0, 0, 0, 5, 0);
      check_all("single hit");
      chk("single rs_data const", b0.rs_data_o, 32'hDEADBEEF);
      chk("single occ const", 32'(b0.occupancy_o), 32'd1);
      for (int i = 0; i < 3; i++) begin
         tick();
         check_all("single bubble");
      end
      chk("single aged out", 32'(b0.rs_hit_o), 32'd0);

      // newest wins
      apply(1, 7, 32'h11, 0, 0, 7, 3); tick();
      apply(1, 7, 32'h22, 0, 0, 7, 3); tick();
      apply(1, 3, 32'h33, 0, 0, 7, 3); tick();
      apply(0, 0, 0, 0, 0, 7, 3);
      check_all("priority");
      chk("priority rs const", b0.rs_data_o, 32'h22);
      chk("priority rt const", b0.rt_data_o, 32'h33);
      chk("priority occ const", 32'(b0.occupancy_o), 32'd3);

      // stall holds, flush overrides stall
      apply(0, 0, 0, 0, 0, 7, 3); tick();
      check_all("pre-stall");
      for (int i = 0; i < 4; i++) begin
         apply(1, 5'(10 + i), 32'(100 + i), 1, 0, 7, 10);
         tick();
         check_all("stall");
      end
      chk("stall occ const", 32'(b0.occupancy_o), 32'd2);
      apply(1, 9, 32'h99, 1, 1, 7, 3); tick();
      apply(0, 0, 0, 0, 0, 7, 3);
      check_all("flush");
      chk("flush occ const", 32'(b0.occupancy_o), 32'd0);

      // r0 and disabled writes
      apply(1, 0, 32'h55, 0, 0, 0, 9); tick();
      apply(0, 9, 32'h66, 0, 0, 0, 9); tick();
      apply(0, 0, 0, 0, 0, 0, 9);
      check_all("r0/disabled");
      chk("r0 occ const", 32'(b0.occupancy_o), 32'd0);

      // live bypass versus registered entry
      apply(1, 4, 32'h10, 0, 0, 4, 0); tick();
      apply(1, 4, 32'h20, 0, 0, 4, 0);
      check_all("bypass");
      chk("bypass on const", b1.rs_data_o, 32'h20);
      chk("bypass off const", b0.rs_data_o, 32'h10);

      // asynchronous reset mid-operation with 3 valid entries
      apply(1, 6, 32'hA1, 0, 0, 6, 4); tick();
      apply(1, 8, 32'hA2, 0, 0, 6, 4); tick();
      apply(0, 0, 0, 0, 0, 6, 4);
      check_all("pre-reset");
      chk("pre-reset occ const", 32'(b0.occupancy_o), 32'd3);
      rst = 1'b1;
      #1;
      hist.delete();
      check_all("mid reset");
      chk("mid reset occ const", 32'(b1.occupancy_o), 32'd0);
      #1 rst = 1'b0;

      // randomized traffic
      for (int n = 0; n < 400; n++) begin
         apply(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), $urandom,
               1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 31) == 0),
               5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
         check_all("random");
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
